ser_rx_fifo: RTL and testbench

- UART receiver with a receive FIFO. It is the downstream consumer of the SoC `ser_tx` line.
- Used in the emulation bench and on the Arty image to capture firmware console output as a byte stream. This replaces the behavioural serial monitor with synthesizable logic.
- Frame format: 8N1, LSB first, idle high. Bit period comes from a run-time divisor, matching the SoC UART divider semantics.

---
 rtl/ser_rx_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_ser_rx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_rx_fifo.sv
// rtl/ser_rx_fifo.sv - 8N1 UART receiver feeding a receive FIFO; optional parity via SER_RX_PARITY_EN
module ser_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int DIV_W = 32
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   rx,
    input  logic [DIV_W-1:0]       cfg_div,
`ifdef SER_RX_PARITY_EN
    input  logic                   cfg_parity_odd,
    output logic                   parity_err,
`endif
    output logic [7:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   frame_err,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t           state, state_n;
    logic             rx_s1, rx_s2, line;
    logic [DIV_W-1:0] cfg_div_eff, div_q, div_n, bcnt, bcnt_n;
    logic [7:0]       sr, sr_n;
    logic [2:0]       bidx, bidx_n;
    logic             bit_tick, push, fe, drop;
    logic             full, push_ok, pop;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
`ifdef SER_RX_PARITY_EN
    logic             par_q, par_n, pe;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end
    assign line = rx_s2;

    assign cfg_div_eff = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    assign bit_tick    = (bcnt == '0);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
            div_q <= DIV_W'(2);
            bcnt  <= '0;
            sr    <= '0;
            bidx  <= '0;
`ifdef SER_RX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            div_q <= div_n;
            bcnt  <= bcnt_n;
            sr    <= sr_n;
            bidx  <= bidx_n;
`ifdef SER_RX_PARITY_EN
            par_q <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div_q;
        bcnt_n  = bcnt;
        sr_n    = sr;
        bidx_n  = bidx;
        push    = 1'b0;
        fe      = 1'b0;
`ifdef SER_RX_PARITY_EN
        par_n   = par_q;
        pe      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                // The 2-flop synchronizer already delays the edge, so start the count one short to land mid-bit
                if (!line) begin
                    div_n   = cfg_div_eff;
                    bcnt_n  = (cfg_div_eff >> 1) - DIV_W'(1);
                    state_n = S_START;
                end
            end
            S_START: begin
                if (!bit_tick) begin
                    bcnt_n = bcnt - DIV_W'(1);
                end else if (line) begin
                    state_n = S_IDLE;
                end else begin
                    bcnt_n  = div_q - DIV_W'(1);
                    bidx_n  = 3'd0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (!bit_tick) begin
                    bcnt_n = bcnt - DIV_W'(1);
                end else begin
                    sr_n   = {line, sr[7:1]};
                    bcnt_n = div_q - DIV_W'(1);
                    bidx_n = bidx + 3'd1;
                    if (bidx == 3'd7) begin
`ifdef SER_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef SER_RX_PARITY_EN
            S_PARITY: begin
                if (!bit_tick) begin
                    bcnt_n = bcnt - DIV_W'(1);
                end else begin
                    par_n   = line;
                    bcnt_n  = div_q - DIV_W'(1);
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!bit_tick) begin
                    bcnt_n = bcnt - DIV_W'(1);
                end else if (line) begin
`ifdef SER_RX_PARITY_EN
                    if (((^sr) ^ par_q) != cfg_parity_odd) pe = 1'b1;
                    else                                   push = 1'b1;
`else
                    push = 1'b1;
`endif
                    state_n = S_IDLE;
                end else begin
                    fe      = 1'b1;
                    state_n = S_BREAK;
                end
            end
            S_BREAK: begin
                if (line) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign full    = (level == LW'(DEPTH));
    assign push_ok = push & ~full;
    assign m_valid = (level != '0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? mem[rd_ptr] : 8'h00;
`ifdef SER_RX_PARITY_EN
    assign drop    = fe | (push & full) | pe;
`else
    assign drop    = fe | (push & full);
`endif

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= sr;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= 8'h00;
`ifdef SER_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            frame_err <= fe;
            overflow  <= push & full;
`ifdef SER_RX_PARITY_EN
            parity_err <= pe;
`endif
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_ser_rx_fifo.sv
// tb/tb_ser_rx_fifo.sv - randomized self-checking bench for ser_rx_fifo against a byte-queue model
module tb_ser_rx_fifo;
    localparam int DEPTH = 16;
    localparam int DIV_W = 32;

    logic                   clk = 1'b0;
    logic                   aresetn = 1'b0;
    logic                   rx = 1'b1;
    logic                   m_ready = 1'b0;
    logic [DIV_W-1:0]       cfg_div = 106;
    logic [7:0]             m_data;
    logic                   m_valid, frame_err, overflow;
    logic [7:0]             drop_cnt;
    logic [$clog2(DEPTH):0] level;
`ifdef SER_RX_PARITY_EN
    logic                   cfg_parity_odd = 1'b0;
    logic                   parity_err;
`endif

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int exp_drop = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       hold_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always #5 clk = ~clk;

    ser_rx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .aresetn(aresetn), .rx(rx), .cfg_div(cfg_div),
`ifdef SER_RX_PARITY_EN
        .cfg_parity_odd(cfg_parity_odd), .parity_err(parity_err),
`endif
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .frame_err(frame_err), .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
    );

    // Observer: collects accepted bytes, counts pulses, checks head stability under backpressure
    always @(negedge clk) begin
        if (aresetn) begin
            if (hold_prev) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== data_prev) begin
                    errors++;
                    $display("FAIL head_hold: valid=%0b data=%02h required valid=1 data=%02h", m_valid, m_data, data_prev);
                end
            end
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (frame_err) fe_cnt++;
            if (overflow)  ov_cnt++;
`ifdef SER_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            hold_prev = m_valid && !m_ready;
            data_prev = m_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int eff_div(input logic [DIV_W-1:0] d);
        return (d < 2) ? 2 : int'(d);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop_bit, input int stop_len, input bit bad_par);
        int d;
        d = eff_div(cfg_div);
        rx = 1'b0;
        tick(d);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(d);
        end
`ifdef SER_RX_PARITY_EN
        rx = (^b) ^ cfg_parity_odd ^ bad_par;
        tick(d);
`endif
        rx = stop_bit;
        tick(d * stop_len);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        tick(3);
        checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %0b required 0", m_valid); end
        checks++; if (level !== '0)      begin errors++; $display("FAIL reset_level: got %0d required 0", level); end
        checks++; if (drop_cnt !== 8'h0) begin errors++; $display("FAIL reset_drop: got %0d required 0", drop_cnt); end
        checks++; if ({frame_err, overflow} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %02b required 00", {frame_err, overflow}); end
        checks++; if (m_data !== 8'h00)  begin errors++; $display("FAIL reset_data: got %02h required 00", m_data); end
        aresetn = 1'b1;
        tick(2);
    endtask

    task automatic test_basic;
        int fe0;
        fe0 = fe_cnt;
        cfg_div = 106;
        m_ready = 1'b1;
        got_q.delete();
        send_byte(8'h55, 1'b1, 1, 1'b0);
        send_byte(8'hA3, 1'b1, 1, 1'b0);
        tick(10);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL basic_count: got %0d required 2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'h55) begin errors++; $display("FAIL basic_b0: got %02h required 55", got_q[0]); end
            checks++; if (got_q[1] !== 8'hA3) begin errors++; $display("FAIL basic_b1: got %02h required a3", got_q[1]); end
        end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL basic_drop: got %0d required %0d", drop_cnt, exp_drop); end
        checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL basic_fe: got %0d pulses required 0", fe_cnt - fe0); end
    endtask

    task automatic test_false_start;
        int fe0;
        fe0 = fe_cnt;
        cfg_div = 106;
        m_ready = 1'b1;
        got_q.delete();
        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(300);
        checks++; if (got_q.size() != 0 || level !== '0) begin errors++; $display("FAIL glitch_push: got %0d bytes level %0d required 0", got_q.size(), level); end
        checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_fe: got %0d pulses required 0", fe_cnt - fe0); end
        send_byte(8'h41, 1'b1, 1, 1'b0);
        tick(10);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h41) begin errors++; $display("FAIL glitch_next: got %0d bytes required one 41", got_q.size()); end
    endtask

    task automatic test_frame_err;
        int fe0;
        fe0 = fe_cnt;
        cfg_div = 106;
        m_ready = 1'b0;
        got_q.delete();
        send_byte(8'h7E, 1'b0, 4, 1'b0);
        tick(300);
        exp_drop++;
        checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d required 1", fe_cnt - fe0); end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL ferr_drop: got %0d required %0d", drop_cnt, exp_drop); end
        checks++; if (level !== '0) begin errors++; $display("FAIL ferr_level: got %0d required 0", level); end
        send_byte(8'h3C, 1'b1, 1, 1'b0);
        tick(10);
        checks++; if (level !== 1 || m_data !== 8'h3C) begin errors++; $display("FAIL ferr_recover: level %0d data %02h required 1 3c", level, m_data); end
        m_ready = 1'b1;
        tick(4);
    endtask

    task automatic test_overflow;
        int ov0, waited;
        ov0 = ov_cnt;
        cfg_div = 16;
        m_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 1'b1, 1, 1'b0);
        tick(10);
        exp_drop++;
        checks++; if (level !== DEPTH) begin errors++; $display("FAIL ovf_level: got %0d required %0d", level, DEPTH); end
        checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL ovf_pulses: got %0d required 1", ov_cnt - ov0); end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL ovf_drop: got %0d required %0d", drop_cnt, exp_drop); end
        m_ready = 1'b1;
        waited = 0;
        while (level != 0 && waited < 100) begin tick(1); waited++; end
        tick(2);
        checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL ovf_drain_count: got %0d required %0d", got_q.size(), DEPTH); end
        else for (int i = 0; i < DEPTH; i++) begin
            checks++; if (got_q[i] !== 8'(i)) begin errors++; $display("FAIL ovf_order[%0d]: got %02h required %02h", i, got_q[i], 8'(i)); end
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: valid %0b required 0", m_valid); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] junk;
        junk = 8'($urandom);
        cfg_div = 16;
        m_ready = 1'b0;
        send_byte(8'h99, 1'b1, 1, 1'b0);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin rx = junk[i]; tick(16); end
        rx = junk[4];
        tick(8);
        aresetn = 1'b0;
        tick(1);
        checks++; if (level !== '0 || m_valid !== 1'b0) begin errors++; $display("FAIL rst_flush: level %0d valid %0b required 0 0", level, m_valid); end
        rx = 1'b1;
        tick(3);
        aresetn = 1'b1;
        exp_drop = 0;
        tick(4);
        got_q.delete();
        m_ready = 1'b1;
        send_byte(8'h12, 1'b1, 1, 1'b0);
        tick(10);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h12) begin errors++; $display("FAIL rst_next: got %0d bytes required one 12", got_q.size()); end
        checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_drop: got %0d required 0", drop_cnt); end
    endtask

    task automatic test_random;
        bit done;
        int waited;
        done = 1'b0;
        got_q.delete();
        exp_q.delete();
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    cfg_div = DIV_W'($urandom_range(24, 0));
                    exp_q.push_back(b);
                    send_byte(b, 1'b1, 1, 1'b0);
                    tick($urandom_range(3, 0));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_ready = ($urandom_range(3, 0) != 0);
                    tick(1);
                end
            end
        join
        m_ready = 1'b1;
        waited = 0;
        while ((level != 0 || got_q.size() < exp_q.size()) && waited < 200) begin tick(1); waited++; end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte[%0d]: got %02h required %02h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL rand_drop: got %0d required %0d", drop_cnt, exp_drop); end
    endtask

`ifdef SER_RX_PARITY_EN
    task automatic test_parity;
        int pe0;
        pe0 = pe_cnt;
        cfg_div = 16;
        cfg_parity_odd = 1'b0;
        m_ready = 1'b1;
        got_q.delete();
        send_byte(8'h03, 1'b1, 1, 1'b0);
        tick(10);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h03) begin errors++; $display("FAIL par_good: got %0d bytes required one 03", got_q.size()); end
        send_byte(8'h03, 1'b1, 1, 1'b1);
        tick(10);
        exp_drop++;
        checks++; if (pe_cnt - pe0 != 1) begin errors++; $display("FAIL par_pulse: got %0d required 1", pe_cnt - pe0); end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL par_drop: got %0d required %0d", drop_cnt, exp_drop); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL par_push: got %0d bytes required 1", got_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overflow();
        test_reset_midframe();
        test_random();
`ifdef SER_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
